// File: rtl/peripheral_bcd_n.sv
// Memory-mapped binary-to-BCD converter for the FemtoRV32 bus.
// Runs a sequential double-dabble engine on an unsigned or two's-complement operand.
module peripheral_bcd_n #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    output logic        irq
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_CTRL   = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_LO     = 3'd3;
    localparam logic [2:0] REG_HI     = 3'd4;

    logic [1:0]       state;
    logic [BIN_W-1:0] operand;
    logic [BIN_W-1:0] bin_sr;
    logic [BCD_W-1:0] bcd_acc;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] result;
    logic [CNT_W-1:0] bit_cnt;
    logic             sign_pend;
    logic             result_sign;
    logic             signed_mode;
    logic             ien;
    logic             done;
    logic             err;
    logic             busy;

    logic [2:0]       reg_sel;
    logic             wr_data;
    logic             wr_ctrl;
    logic             wr_status;
    logic             rd_lo;
    logic [31:0]      rdata;
    logic [63:0]      res_pad;

    logic [BIN_W:0]   op_ext;
    logic [BIN_W:0]   op_neg;
    logic             start_neg;
    logic [BIN_W-1:0] start_mag;
    logic             unused_bits;

    assign reg_sel   = addr[4:2];
    assign wr_data   = cs & wr & (reg_sel == REG_DATA);
    assign wr_ctrl   = cs & wr & (reg_sel == REG_CTRL);
    assign wr_status = cs & wr & (reg_sel == REG_STATUS);
    assign rd_lo     = cs & rd & (reg_sel == REG_LO);
    assign busy      = (state != IDLE);
    assign irq       = done & ien;
    assign res_pad   = 64'(result);

    // Negation is done one bit wider so the most negative operand maps to an exact magnitude.
    assign op_ext    = {d_in[BIN_W-1], d_in[BIN_W-1:0]};
    assign op_neg    = -op_ext;
    assign start_neg = signed_mode & d_in[BIN_W-1];
    assign start_mag = start_neg ? op_neg[BIN_W-1:0] : d_in[BIN_W-1:0];

    assign unused_bits = ^{d_in, addr[1:0], op_neg[BIN_W], res_pad[63]};

    always_comb begin
        bcd_adj = bcd_acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_acc[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (reg_sel)
            REG_DATA:   rdata = 32'(operand);
            REG_CTRL:   rdata = {30'd0, ien, signed_mode};
            REG_STATUS: rdata = {29'd0, err, done, busy};
            REG_LO:     rdata = res_pad[31:0];
            REG_HI:     rdata = {result_sign, res_pad[62:32]};
            default:    rdata = 32'd0;
        endcase
    end

    // Later assignments to done win, so a FINISH set overrides a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            operand     <= '0;
            bin_sr      <= '0;
            bcd_acc     <= '0;
            result      <= '0;
            bit_cnt     <= '0;
            sign_pend   <= 1'b0;
            result_sign <= 1'b0;
            signed_mode <= 1'b0;
            ien         <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            d_out       <= 32'd0;
        end else begin
            if (cs && rd)
                d_out <= rdata;
            if (wr_ctrl)
                {ien, signed_mode} <= d_in[1:0];
            if (wr_status && d_in[1])
                done <= 1'b0;
            if (wr_status && d_in[2])
                err <= 1'b0;
            if (rd_lo)
                done <= 1'b0;
            if (wr_data && busy)
                err <= 1'b1;

            case (state)
                IDLE: begin
                    if (wr_data) begin
                        operand   <= d_in[BIN_W-1:0];
                        bin_sr    <= start_mag;
                        sign_pend <= start_neg;
                        bcd_acc   <= '0;
                        done      <= 1'b0;
                        bit_cnt   <= CNT_W'(BIN_W);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_acc <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
                    bin_sr  <= bin_sr << 1;
                    bit_cnt <= bit_cnt - CNT_W'(1);
                    if (bit_cnt == CNT_W'(1))
                        state <= FINISH;
                end
                FINISH: begin
                    result      <= bcd_acc;
                    result_sign <= sign_pend;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_bcd_n.sv
// Bench for peripheral_bcd_n: a 16-bit/5-digit instance and a 32-bit/10-digit instance
// share one bus; sel routes cs and read data to the chosen instance.
module tb_peripheral_bcd_n;

    localparam logic [4:0] A_DATA   = 5'd0;
    localparam logic [4:0] A_CTRL   = 5'd4;
    localparam logic [4:0] A_STATUS = 5'd8;
    localparam logic [4:0] A_LO     = 5'd12;
    localparam logic [4:0] A_HI     = 5'd16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] d_in = 32'd0;
    logic        cs = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic        sel = 1'b0;
    logic        cs_a, cs_b, irq_a, irq_b;
    logic [31:0] d_out_a, d_out_b;
    logic [31:0] d_out;
    logic        irq;

    assign cs_a  = cs & ~sel;
    assign cs_b  = cs & sel;
    assign d_out = sel ? d_out_b : d_out_a;
    assign irq   = sel ? irq_b : irq_a;

    always #5 clk = ~clk;

    peripheral_bcd_n #(.BIN_W(16), .DIGITS(5)) dut_a (
        .clk(clk), .reset(reset), .d_in(d_in), .cs(cs_a), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out_a), .irq(irq_a)
    );

    peripheral_bcd_n #(.BIN_W(32), .DIGITS(10)) dut_b (
        .clk(clk), .reset(reset), .d_in(d_in), .cs(cs_b), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out_b), .irq(irq_b)
    );

    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] data;
        logic [31:0] expLo;
        logic [31:0] expHi;
    } vec_t;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    exp_t sbQueue[$];
    int   assertCount = 0;
    int   failCount = 0;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] expv);
        assertCount++;
        if (act !== expv) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic busWrite(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic busRead(input logic [4:0] a, output logic [31:0] v);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        v = d_out;
        cs = 1'b0; rd = 1'b0;
    endtask

    function automatic exp_t modelBcd(input int w, input logic [31:0] ctrl, input logic [31:0] data);
        exp_t            r;
        logic [31:0]     masked;
        logic            neg;
        longint unsigned mag;
        logic [63:0]     dig;
        masked = (w == 32) ? data : (data & ((32'd1 << w) - 32'd1));
        neg    = ctrl[0] && masked[w-1];
        mag    = neg ? ((64'd1 << w) - 64'(masked)) : 64'(masked);
        dig    = 64'd0;
        for (int i = 0; i < 16; i++) begin
            dig[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        r.lo = dig[31:0];
        r.hi = dig[63:32];
        r.hi[31] = neg;
        return r;
    endfunction

    task automatic applyStimulus(input logic [31:0] ctrl, input logic [31:0] data,
                                 input logic [31:0] lo, input logic [31:0] hi);
        exp_t e;
        busWrite(A_CTRL, ctrl);
        busWrite(A_DATA, data);
        e.lo = lo;
        e.hi = hi;
        sbQueue.push_back(e);
    endtask

    // expBusy of 0 skips the latency check for sequences that spend cycles elsewhere.
    task automatic checkOutput(input string name, input int expBusy, input logic [31:0] expStatus,
                               input logic ienExp);
        int          busyCount = 0;
        logic        finished = 1'b0;
        logic [31:0] st;
        logic [31:0] v;
        exp_t        e;
        for (int k = 0; k < 100 && !finished; k++) begin
            busRead(A_STATUS, st);
            if (st[0]) busyCount++;
            else finished = 1'b1;
        end
        checkEq({name, " finished"}, 32'(finished), 32'd1);
        if (expBusy > 0)
            checkEq({name, " busy cycles"}, 32'(busyCount), 32'(expBusy));
        checkEq({name, " status"}, st, expStatus);
        checkEq({name, " irq before read"}, 32'(irq), 32'(ienExp));
        checkEq({name, " scoreboard depth"}, 32'(sbQueue.size()), 32'd1);
        if (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            busRead(A_LO, v);
            checkEq({name, " RESULT_LO"}, v, e.lo);
            busRead(A_HI, v);
            checkEq({name, " RESULT_HI"}, v, e.hi);
            checkEq({name, " irq after read"}, 32'(irq), 32'd0);
            busRead(A_STATUS, v);
            checkEq({name, " status after read"}, v, expStatus & ~32'd2);
        end
    endtask

    vec_t vecs[8];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] ctrl;
        logic [31:0] data;
        exp_t        e;

        vecs[0] = '{32'd0, 32'h0000FFFF, 32'h00065535, 32'h00000000};
        vecs[1] = '{32'd1, 32'h0000FFFF, 32'h00000001, 32'h80000000};
        vecs[2] = '{32'd1, 32'h00008000, 32'h00032768, 32'h80000000};
        vecs[3] = '{32'd1, 32'h00007FFF, 32'h00032767, 32'h00000000};
        vecs[4] = '{32'd2, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[5] = '{32'd0, 32'h000004D2, 32'h00001234, 32'h00000000};
        vecs[6] = '{32'd0, 32'h00008000, 32'h00032768, 32'h00000000};
        vecs[7] = '{32'd3, 32'h0000FFF6, 32'h00000010, 32'h80000000};

        repeat (3) tick();
        reset = 1'b1;
        tick();

        $display("[TB] reset state");
        checkEq("reset d_out", d_out, 32'd0);
        checkEq("reset irq", 32'(irq), 32'd0);
        busRead(A_CTRL, v);   checkEq("reset CTRL", v, 32'd0);
        busRead(A_STATUS, v); checkEq("reset STATUS", v, 32'd0);
        busRead(A_LO, v);     checkEq("reset RESULT_LO", v, 32'd0);
        busRead(A_HI, v);     checkEq("reset RESULT_HI", v, 32'd0);
        busRead(A_DATA, v);   checkEq("reset DATA", v, 32'd0);

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].ctrl, vecs[i].data, vecs[i].expLo, vecs[i].expHi);
            checkOutput($sformatf("vec%0d", i), 17, 32'd2, vecs[i].ctrl[1]);
        end

        $display("[TB] random vectors");
        for (int i = 0; i < 6; i++) begin
            ctrl = 32'($urandom_range(0, 1));
            data = 32'($urandom_range(0, 65535));
            e = modelBcd(16, ctrl, data);
            applyStimulus(ctrl, data, e.lo, e.hi);
            checkOutput($sformatf("rand%0d", i), 17, 32'd2, 1'b0);
        end

        $display("[TB] DATA write while busy");
        applyStimulus(32'd0, 32'd1234, 32'h00001234, 32'h00000000);
        repeat (4) tick();
        busWrite(A_DATA, 32'd9999);
        checkOutput("busy write", 0, 32'h6, 1'b0);
        busRead(A_DATA, v);   checkEq("busy write DATA kept", v, 32'd1234);
        busWrite(A_STATUS, 32'h6);
        busRead(A_STATUS, v); checkEq("W1C clears status", v, 32'd0);

        $display("[TB] RESULT_LO read in FINISH cycle");
        busWrite(A_DATA, 32'd42);
        repeat (16) tick();
        busRead(A_LO, v);     checkEq("finish read old result", v, 32'h00001234);
        busRead(A_STATUS, v); checkEq("finish read keeps done", v, 32'h2);
        busRead(A_LO, v);     checkEq("finish read new result", v, 32'h00000042);

        $display("[TB] STATUS W1C in FINISH cycle");
        busWrite(A_DATA, 32'd7);
        repeat (16) tick();
        busWrite(A_STATUS, 32'h2);
        busRead(A_STATUS, v); checkEq("finish W1C set wins", v, 32'h2);
        busRead(A_LO, v);     checkEq("finish W1C result", v, 32'h00000007);

        $display("[TB] reset during conversion");
        busWrite(A_CTRL, 32'h2);
        busWrite(A_DATA, 32'h1234);
        repeat (7) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkEq("abort irq", 32'(irq), 32'd0);
        checkEq("abort d_out", d_out, 32'd0);
        busRead(A_STATUS, v); checkEq("abort STATUS", v, 32'd0);
        busRead(A_LO, v);     checkEq("abort RESULT_LO", v, 32'd0);
        repeat (30) tick();
        busRead(A_STATUS, v); checkEq("abort no FINISH STATUS", v, 32'd0);
        busRead(A_LO, v);     checkEq("abort no FINISH RESULT_LO", v, 32'd0);
        checkEq("abort no FINISH irq", 32'(irq), 32'd0);

        $display("[TB] 32-bit instance");
        sel = 1'b1;
        applyStimulus(32'd0, 32'hFFFFFFFF, 32'h94967295, 32'h00000042);
        checkOutput("w32 max", 33, 32'd2, 1'b0);
        e = modelBcd(32, 32'd1, 32'h80000000);
        applyStimulus(32'd1, 32'h80000000, e.lo, e.hi);
        checkOutput("w32 min signed", 33, 32'd2, 1'b0);
        sel = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
